// File: rtl/regfile_wb_arbiter.sv
// Two-port writeback arbiter for the register file's single write port.
// Emits a clean one-cycle Write pulse and holds address/data stable around it.
module regfile_wb_arbiter #(
  parameter int HOLD_CYCLES = 1,
  parameter bit RR_ENABLE   = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Req0_Valid,
  input  logic [4:0]  Req0_Addr,
  input  logic [31:0] Req0_Data,
  output logic        Req0_Ready,
  input  logic        Req1_Valid,
  input  logic [4:0]  Req1_Addr,
  input  logic [31:0] Req1_Data,
  output logic        Req1_Ready,
  output logic [4:0]  C_Address,
  output logic [31:0] C_Data,
  output logic        Write,
  output logic        Busy,
  output logic [31:0] Pending_Mask,
  output logic        Dropped
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [1:0] HOLD_LAST = 2'(HOLD_CYCLES - 1);

  state_e      state_q;
  logic [1:0]  hold_cnt_q;
  logic        rr_last_q;
  logic [4:0]  c_addr_q;
  logic [31:0] c_data_q;
  logic        write_q;
  logic        busy_q;
  logic [31:0] pend_q;
  logic        dropped_q;

  logic        gnt0_s;
  logic        gnt1_s;
  logic        accept_s;
  logic [4:0]  acc_addr_s;
  logic [31:0] acc_data_s;

  // Grant selection; rr_last_q records the port granted most recently.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (Reset_n && (state_q == ST_IDLE)) begin
      if (Req0_Valid && Req1_Valid) begin
        if (RR_ENABLE && (rr_last_q == 1'b0)) begin
          gnt1_s = 1'b1;
        end else begin
          gnt0_s = 1'b1;
        end
      end else begin
        gnt0_s = Req0_Valid;
        gnt1_s = Req1_Valid;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  assign accept_s   = gnt0_s | gnt1_s;
  assign acc_addr_s = gnt1_s ? Req1_Addr : Req0_Addr;
  assign acc_data_s = gnt1_s ? Req1_Data : Req0_Data;

  // Writeback FSM with registered strobe, address, data and status outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= 2'd0;
      rr_last_q  <= 1'b1;
      c_addr_q   <= 5'd0;
      c_data_q   <= 32'd0;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
      pend_q     <= 32'd0;
      dropped_q  <= 1'b0;
    end else begin
      dropped_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            rr_last_q <= gnt1_s;
            if (acc_addr_s != 5'd0) begin
              state_q  <= ST_ISSUE;
              c_addr_q <= acc_addr_s;
              c_data_q <= acc_data_s;
              write_q  <= 1'b1;
              busy_q   <= 1'b1;
              pend_q   <= 32'd1 << acc_addr_s;
            end else begin
              dropped_q <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          write_q    <= 1'b0;
          state_q    <= ST_HOLD;
          hold_cnt_q <= HOLD_LAST;
        end
        ST_HOLD: begin
          if (hold_cnt_q == 2'd0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            pend_q  <= 32'd0;
          end else begin
            hold_cnt_q <= hold_cnt_q - 2'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          write_q <= 1'b0;
          busy_q  <= 1'b0;
          pend_q  <= 32'd0;
        end
      endcase
    end
  end

  assign Req0_Ready   = gnt0_s;
  assign Req1_Ready   = gnt1_s;
  assign C_Address    = c_addr_q;
  assign C_Data       = c_data_q;
  assign Write        = write_q;
  assign Busy         = busy_q;
  assign Pending_Mask = pend_q;
  assign Dropped      = dropped_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance share stimulus.
module tb_regfile_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [4:0]  a0 = 5'd0, a1 = 5'd0;
  logic [31:0] d0 = 32'd0, d1 = 32'd0;

  logic        r_rdy0, r_rdy1, r_wr, r_busy, r_drop;
  logic [4:0]  r_addr;
  logic [31:0] r_data, r_pend;
  logic        f_rdy0, f_rdy1, f_wr, f_busy, f_drop;
  logic [4:0]  f_addr;
  logic [31:0] f_data, f_pend;

  int passed = 0;
  int total  = 0;

  always #5 Clk = ~Clk;

  regfile_wb_arbiter #(.HOLD_CYCLES(1), .RR_ENABLE(1'b1)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Req0_Valid(v0), .Req0_Addr(a0), .Req0_Data(d0), .Req0_Ready(r_rdy0),
    .Req1_Valid(v1), .Req1_Addr(a1), .Req1_Data(d1), .Req1_Ready(r_rdy1),
    .C_Address(r_addr), .C_Data(r_data), .Write(r_wr), .Busy(r_busy),
    .Pending_Mask(r_pend), .Dropped(r_drop)
  );

  regfile_wb_arbiter #(.HOLD_CYCLES(1), .RR_ENABLE(1'b0)) dut_fp (
    .Clk(Clk), .Reset_n(Reset_n),
    .Req0_Valid(v0), .Req0_Addr(a0), .Req0_Data(d0), .Req0_Ready(f_rdy0),
    .Req1_Valid(v1), .Req1_Addr(a1), .Req1_Data(d1), .Req1_Ready(f_rdy1),
    .C_Address(f_addr), .C_Data(f_data), .Write(f_wr), .Busy(f_busy),
    .Pending_Mask(f_pend), .Dropped(f_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    // Reset held while port 0 is requesting
    v0 = 1'b1; a0 = 5'd5; d0 = 32'hDEADBEEF;
    tick(); tick();
    chk("rst_write", {31'd0, r_wr}, 32'd0);
    chk("rst_addr", {27'd0, r_addr}, 32'd0);
    chk("rst_data", r_data, 32'd0);
    chk("rst_rdy0", {31'd0, r_rdy0}, 32'd0);
    chk("rst_rdy1", {31'd0, r_rdy1}, 32'd0);
    chk("rst_pend", r_pend, 32'd0);
    chk("rst_busy", {31'd0, r_busy}, 32'd0);
    Reset_n = 1'b1;
    #1;
    chk("rel_rdy0", {31'd0, r_rdy0}, 32'd1);

    // Single write from port 0
    tick();
    chk("sw_write", {31'd0, r_wr}, 32'd1);
    chk("sw_addr", {27'd0, r_addr}, 32'd5);
    chk("sw_data", r_data, 32'hDEADBEEF);
    chk("sw_pend", r_pend, 32'h20);
    chk("sw_busy", {31'd0, r_busy}, 32'd1);
    chk("sw_rdy0_issue", {31'd0, r_rdy0}, 32'd0);
    v0 = 1'b0;
    tick();
    chk("sw_write_fall", {31'd0, r_wr}, 32'd0);
    chk("sw_addr_hold", {27'd0, r_addr}, 32'd5);
    chk("sw_data_hold", r_data, 32'hDEADBEEF);
    chk("sw_busy_hold", {31'd0, r_busy}, 32'd1);
    v0 = 1'b1; a0 = 5'd6; d0 = 32'h0000_0066;
    #1;
    chk("sw_rdy0_hold", {31'd0, r_rdy0}, 32'd0);
    tick();
    #1;
    chk("sw_idle_busy", {31'd0, r_busy}, 32'd0);
    chk("sw_idle_pend", r_pend, 32'd0);
    chk("sw_idle_addr", {27'd0, r_addr}, 32'd5);
    chk("sw_idle_rdy0", {31'd0, r_rdy0}, 32'd1);
    v0 = 1'b0;

    // Fresh reset, then both ports continuously valid
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    v0 = 1'b1; a0 = 5'd1; d0 = 32'h11;
    v1 = 1'b1; a1 = 5'd2; d1 = 32'h22;
    #1;
    chk("rr_first_rdy0", {31'd0, r_rdy0}, 32'd1);
    chk("fp_first_rdy0", {31'd0, f_rdy0}, 32'd1);
    for (int k = 1; k <= 15; k++) begin
      tick();
      #1;
      chk($sformatf("rr_wr_k%0d", k), {31'd0, r_wr}, {31'd0, (k % 3) == 1});
      chk($sformatf("fp_wr_k%0d", k), {31'd0, f_wr}, {31'd0, (k % 3) == 1});
      if ((k % 3) == 1) begin
        chk($sformatf("rr_addr_k%0d", k), {27'd0, r_addr}, ((k / 3) % 2 == 0) ? 32'd1 : 32'd2);
        chk($sformatf("fp_addr_k%0d", k), {27'd0, f_addr}, 32'd1);
      end
      chk($sformatf("rr_onehot_k%0d", k), {31'd0, r_rdy0 & r_rdy1}, 32'd0);
      chk($sformatf("fp_rdy1_k%0d", k), {31'd0, f_rdy1}, {31'd0, k == 15});
      if (k == 13) v0 = 1'b0;
    end
    tick();
    chk("rr_last_addr", {27'd0, r_addr}, 32'd2);
    chk("fp_port1_addr", {27'd0, f_addr}, 32'd2);
    chk("fp_port1_data", f_data, 32'h22);
    v1 = 1'b0;
    tick(); tick();

    // r0 request is dropped, the next one is accepted at once
    v1 = 1'b1; a1 = 5'd0; d1 = 32'd7;
    #1;
    chk("r0_rdy1", {31'd0, r_rdy1}, 32'd1);
    tick();
    chk("r0_dropped", {31'd0, r_drop}, 32'd1);
    chk("r0_write", {31'd0, r_wr}, 32'd0);
    chk("r0_busy", {31'd0, r_busy}, 32'd0);
    chk("r0_pend", r_pend, 32'd0);
    a1 = 5'd3; d1 = 32'h33;
    #1;
    chk("r0_next_rdy1", {31'd0, r_rdy1}, 32'd1);
    tick();
    chk("r3_write", {31'd0, r_wr}, 32'd1);
    chk("r3_addr", {27'd0, r_addr}, 32'd3);
    chk("r3_data", r_data, 32'h33);
    chk("r3_pend", r_pend, 32'h8);
    chk("r3_drop_clr", {31'd0, r_drop}, 32'd0);
    v1 = 1'b0;
    tick();
    chk("hold_busy", {31'd0, r_busy}, 32'd1);

    // Reset asserted in HOLD clears outputs without waiting for a clock
    Reset_n = 1'b0;
    #1;
    chk("hrst_busy", {31'd0, r_busy}, 32'd0);
    chk("hrst_pend", r_pend, 32'd0);
    chk("hrst_write", {31'd0, r_wr}, 32'd0);
    chk("hrst_addr", {27'd0, r_addr}, 32'd0);
    tick();
    Reset_n = 1'b1;
    v1 = 1'b1; a1 = 5'd9; d1 = 32'h99;
    #1;
    chk("post_rdy1", {31'd0, r_rdy1}, 32'd1);
    tick();
    chk("post_write", {31'd0, r_wr}, 32'd1);
    chk("post_addr", {27'd0, r_addr}, 32'd9);
    chk("post_data", r_data, 32'h99);
    chk("post_pend", r_pend, 32'h200);
    v1 = 1'b0;
    tick();
    chk("post_wr_fall", {31'd0, r_wr}, 32'd0);
    chk("post_data_hold", r_data, 32'h99);
    tick();
    chk("post_idle_busy", {31'd0, r_busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (C_Address, C_Data, Write) between two writeback requesters: port 0 (ALU) and port 1 (memory load).
- The register file writes on the rising edge of Write. This block therefore generates a clean one-cycle Write pulse and holds address and data stable around it.
- Provides Pending_Mask so decode/stall logic can detect registers with a write in flight.
- Sits between the execute/memory stages and the register file.

Parameters:
- HOLD_CYCLES, 1, cycles C_Address/C_Data stay stable after Write falls (1..4); covers the register file's #1 internal write delay.
- RR_ENABLE, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 always wins.

Ports:
- Clk  in  1  clock; all state changes on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- Req0_Valid  in  1  port 0 write request.
- Req0_Addr  in  5  port 0 destination register.
- Req0_Data  in  32  port 0 write data.
- Req0_Ready  out  1  port 0 request accepted this cycle when Valid&Ready.
- Req1_Valid  in  1  port 1 write request.
- Req1_Addr  in  5  port 1 destination register.
- Req1_Data  in  32  port 1 write data.
- Req1_Ready  out  1  port 1 accept.
- C_Address  out  5  register file write address (registered).
- C_Data  out  32  register file write data (registered).
- Write  out  1  register file write strobe (registered, one-cycle pulse).
- Busy  out  1  high in ISSUE and HOLD states.
- Pending_Mask  out  32  one-hot bit of the register being written, else 0.
- Dropped  out  1  one-cycle pulse when an accepted request targeted r0.

Behaviour:
- Reset (async, Reset_n=0): state IDLE, Write=0, C_Address=0, C_Data=0, Busy=0, Pending_Mask=0, Dropped=0, RR pointer favours port 0. Both Ready outputs are 0 while Reset_n=0.
- States:
  - IDLE: grant logic active.
  - ISSUE: Write=1 for exactly one cycle.
  - HOLD: Write=0; address and data unchanged; counter runs HOLD_CYCLES cycles.
- Grant (combinational, IDLE only):
  - One valid: that port is granted.
  - Both valid, RR_ENABLE=1: grant the port not granted last.
  - Both valid, RR_ENABLE=0: grant port 0.
- Ready is asserted only for the granted port, only in IDLE. Never both Readies at once. Ready=0 in ISSUE/HOLD.
- Requester rules: hold Valid, Addr and Data stable until accepted. Valid may drop only after acceptance.
- Accept with Addr!=0:
  - Next cycle: state ISSUE; C_Address/C_Data loaded; Write=1; Busy=1; Pending_Mask[Addr]=1.
  - Accept-to-Write-rise latency is 1 cycle.
- ISSUE always goes to HOLD after 1 cycle.
- HOLD lasts HOLD_CYCLES cycles, then IDLE.
  - Busy and Pending_Mask clear on entry to IDLE.
  - C_Address/C_Data keep their last values in IDLE until the next accept (no glitch).
- Accept with Addr=0:
  - Request is consumed; Dropped=1 the next cycle.
  - State stays IDLE; no Write pulse; Pending_Mask unchanged (0).
  - RR pointer updates as for a normal grant.
- RR pointer updates on every accept, including r0 drops.
- Throughput: one write per HOLD_CYCLES+2 cycles. Back-to-back requests see Ready in the first IDLE cycle.
- Simultaneous requests to the same Addr are serialized in grant order; the later write wins in the register file.
- Reset mid-ISSUE/HOLD: outputs clear immediately and asynchronously. The write in flight is lost or completed undefined; requesters must re-issue after reset.
- Write is never high for two consecutive cycles.

Test Plan:
- Reset: Reset_n=0 while Req0_Valid=1 -> Write=0, C_Address=0, C_Data=0, Ready0=Ready1=0, Pending_Mask=0. Release -> Ready0=1 the same cycle.
- Single write: Req0 Addr=5, Data=32'hDEADBEEF accepted at cycle t -> Write=1 at t+1 with C_Address=5, C_Data=DEADBEEF, Pending_Mask=32'h20. Write=0 at t+2, address/data held. IDLE and Ready0=1 again at t+3 (HOLD_CYCLES=1).
- Round-robin: both ports continuously valid (Addr 1 and 2), RR_ENABLE=1 -> Write pulses alternate C_Address 1,2,1,2, spaced 3 cycles apart.
- Fixed priority: RR_ENABLE=0, both valid -> port 0 granted every time; Req1_Ready stays 0 until Req0_Valid drops.
- r0 drop: Req1 Addr=0, Data=7 -> Dropped=1 the next cycle, Write stays 0, no state change. Following Req1 Addr=3 is accepted on the very next cycle.
- Reset during HOLD: assert Reset_n=0 in HOLD -> Busy, Pending_Mask and Write clear immediately. After release, the next request completes normally with correct address and data.
